// File: rtl/bcd_display_scan.sv
// Scans a latched 3-digit BCD amount onto a 4-digit common-anode 7-segment display,
// with per-slot dead time, leading-zero blanking, whole-display blink and a dash for bad digits.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_HUND = 2'd2,
    SLOT_LEFT = 2'd3
  } slot_e;

  logic [PW-1:0] presc_q, presc_d;
  slot_e         slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;
  logic [3:0]    shadow_o_q, shadow_o_d;
  logic [3:0]    shadow_t_q, shadow_t_d;
  logic [1:0]    shadow_h_q, shadow_h_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic       presc_wrap;
  logic       frame_done;
  logic [3:0] digit;
  logic [3:0] an_sel;
  logic       blank;
  logic       lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    slot_d     = presc_wrap ? slot_e'(slot_q + 2'd1) : slot_q;
    frame_done = presc_wrap && (slot_q == SLOT_LEFT);
    frame_d    = frame_q;
    phase_d    = phase_q;
    if (frame_done) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end

    shadow_o_d = load ? ones     : shadow_o_q;
    shadow_t_d = load ? tens     : shadow_t_q;
    shadow_h_d = load ? hundreds : shadow_h_q;

    digit  = 4'd0;
    an_sel = 4'b1111;
    blank  = 1'b1;
    case (slot_q)
      SLOT_ONES: begin
        digit  = shadow_o_q;
        an_sel = 4'b1110;
        blank  = 1'b0;
      end
      SLOT_TENS: begin
        digit  = shadow_t_q;
        an_sel = 4'b1101;
        blank  = blank_lz && (shadow_h_q == 2'd0) && (shadow_t_q == 4'd0);
      end
      SLOT_HUND: begin
        // hundreds=3 is out of range for the amount, so force it onto the dash code
        digit  = (shadow_h_q == 2'd3) ? 4'hF : {2'b00, shadow_h_q};
        an_sel = 4'b1011;
        blank  = blank_lz && (shadow_h_q == 2'd0);
      end
      default: ;
    endcase

    // First cycle of every slot is anode dead time to avoid ghosting.
    lit   = (presc_q != '0) && !blank && !(blink_en && phase_q);
    an_d  = lit ? an_sel : 4'b1111;
    seg_d = lit ? seg_decode(digit) : 7'b1111111;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      slot_q     <= SLOT_ONES;
      frame_q    <= '0;
      phase_q    <= 1'b0;
      shadow_o_q <= 4'd0;
      shadow_t_q <= 4'd0;
      shadow_h_q <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
    end else begin
      presc_q    <= presc_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      phase_q    <= phase_d;
      shadow_o_q <= shadow_o_d;
      shadow_t_q <= shadow_t_d;
      shadow_h_q <= shadow_h_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
